// File: rtl/image_rom_scanner.sv
// ----------------------------------------------------------------------------
// image_rom_scanner
//   Read-side client for the synchronous 9-bit image ROM. Walks one frame in
//   raster order and drives the ROM address. Absorbs the fixed ROM read
//   latency with an in-flight flag pipeline and a small skid FIFO. Emits the
//   pixels as a valid/ready stream with x/y/sof/eol sideband.
//
//   The first read of a frame is issued in the first SCAN cycle. Returning ROM
//   data that finds the FIFO empty is presented combinationally on pix_*. This
//   lets the first pix_valid appear 1+ROM_LAT clocks after start. Data is
//   stored in the FIFO only when the sink does not take it in that cycle.
//
// Optional feature: define IMAGE_SCAN_MIRROR_EN to add the 'mirror' input.
//   It is sampled on an accepted start and held for the frame. When set, each
//   line is read right-to-left; pix_x still counts up.
//
// Ports
//   clk        system clock, shared with the ROM
//   reset_n    asynchronous active-low reset
//   start      1-cycle pulse, begins a frame when idle
//   mirror     (IMAGE_SCAN_MIRROR_EN only) horizontal mirror for the frame
//   busy       frame in progress
//   done       1-cycle pulse after the last pixel handshake
//   rom_ad     ROM word address
//   rom_data   ROM read data, ROM_LAT clocks after rom_ad
//   pix_valid  pixel available
//   pix_ready  sink accepts pixel
//   pix_data   pixel value
//   pix_x      screen column of pix_data
//   pix_y      line of pix_data
//   pix_sof    pixel is (0,0)
//   pix_eol    pixel is last of its line
// ----------------------------------------------------------------------------
module image_rom_scanner #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 9,
   parameter int IMG_W   = 64,
   parameter int IMG_H   = 64,
   parameter int BASE    = 0,
   parameter int ROM_LAT = 1,
   localparam int XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1,
   localparam int YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
`ifdef IMAGE_SCAN_MIRROR_EN
   input  logic              mirror,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_ad,
   input  logic [DATA_W-1:0] rom_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [DATA_W-1:0] pix_data,
   output logic [XW-1:0]     pix_x,
   output logic [YW-1:0]     pix_y,
   output logic              pix_sof,
   output logic              pix_eol
);

   localparam int DEPTH = ROM_LAT + 1;   // skid FIFO depth, 2 or 3

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic          sof;
      logic          eol;
   } side_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      side_t             side;
   } ent_t;

   state_t              state_q, state_d;
   logic [XW-1:0]       x_rd_q, x_rd_d;
   logic [YW-1:0]       y_rd_q, y_rd_d;
   logic [ADDR_W-1:0]   lbase_q, lbase_d;
   logic                mirror_q;
   logic                start_acc;

   logic [ROM_LAT-1:0]  infl_q;
   side_t               side_pipe_q [ROM_LAT];
   ent_t                mem_q [4];
   logic [1:0]          wr_ptr_q, rd_ptr_q, cnt_q;
   logic                done_q;

   logic                last_col, last_row, issue, pop, arrive;
   logic                fifo_empty, fifo_wr, fifo_rd, last_pop;
   logic [1:0]          infl_cnt;
   logic [2:0]          occ;
   logic [XW-1:0]       col;
   side_t               issue_side;
   ent_t                arr_ent, head;

   // ---------------------------------------------------------------- address
   assign last_col = (x_rd_q == XW'(IMG_W - 1));
   assign last_row = (y_rd_q == YW'(IMG_H - 1));
   assign col      = mirror_q ? (XW'(IMG_W - 1) - x_rd_q) : x_rd_q;
   assign rom_ad   = ADDR_W'(BASE) + lbase_q + ADDR_W'(col);

   assign issue_side.x   = x_rd_q;
   assign issue_side.y   = y_rd_q;
   assign issue_side.sof = (x_rd_q == '0) && (y_rd_q == '0);
   assign issue_side.eol = last_col;

   // --------------------------------------------------------- issue control
   always_comb begin
      infl_cnt = '0;
      for (int i = 0; i < ROM_LAT; i++) infl_cnt = infl_cnt + 2'(infl_q[i]);
   end

   // Everything already promised a slot (stored, in flight) minus what leaves
   // this cycle must leave room for one more read.
   assign occ   = 3'(cnt_q) + 3'(infl_cnt) - 3'(pop);
   assign issue = (state_q == S_SCAN) && (occ < 3'(DEPTH));

   // ------------------------------------------------------------- FIFO head
   assign arrive     = infl_q[ROM_LAT-1];
   assign arr_ent    = '{data: rom_data, side: side_pipe_q[ROM_LAT-1]};
   assign fifo_empty = (cnt_q == 2'd0);

   always_comb begin
      head = '0;
      if (!fifo_empty) head = mem_q[rd_ptr_q];
      else if (arrive) head = arr_ent;
   end

   assign pix_valid = !fifo_empty || arrive;
   assign pix_data  = head.data;
   assign pix_x     = head.side.x;
   assign pix_y     = head.side.y;
   assign pix_sof   = head.side.sof;
   assign pix_eol   = head.side.eol;

   assign pop      = pix_valid && pix_ready;
   assign fifo_rd  = pop && !fifo_empty;
   // Arriving data bypasses storage only if it goes straight out.
   assign fifo_wr  = arrive && !(fifo_empty && pop);
   assign last_pop = pop && head.side.eol && (head.side.y == YW'(IMG_H - 1));

   assign busy = (state_q != S_IDLE);
   assign done = done_q;

   // -------------------------------------------------------------------- FSM
   always_comb begin
      state_d   = state_q;
      x_rd_d    = x_rd_q;
      y_rd_d    = y_rd_q;
      lbase_d   = lbase_q;
      start_acc = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_SCAN;
               start_acc = 1'b1;
            end
         end
         S_SCAN: begin
            if (issue) begin
               if (last_col) begin
                  x_rd_d = '0;
                  if (last_row) begin
                     // counters return to zero so the next frame starts clean
                     y_rd_d  = '0;
                     lbase_d = '0;
                     state_d = S_DRAIN;
                  end else begin
                     y_rd_d  = y_rd_q + YW'(1);
                     lbase_d = lbase_q + ADDR_W'(IMG_W);
                  end
               end else begin
                  x_rd_d = x_rd_q + XW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (last_pop) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         x_rd_q  <= '0;
         y_rd_q  <= '0;
         lbase_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_rd_q  <= x_rd_d;
         y_rd_q  <= y_rd_d;
         lbase_q <= lbase_d;
         done_q  <= last_pop;
      end
   end

`ifdef IMAGE_SCAN_MIRROR_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       mirror_q <= 1'b0;
      else if (start_acc) mirror_q <= mirror;
   end
`else
   assign mirror_q = 1'b0;
`endif

   // ---------------------------------------------------- in-flight pipeline
   // Clearing the flags on reset drops any ROM data still on its way.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         infl_q <= '0;
         for (int i = 0; i < ROM_LAT; i++) side_pipe_q[i] <= '0;
      end else begin
         infl_q         <= (infl_q << 1) | ROM_LAT'(issue);
         side_pipe_q[0] <= issue_side;
         for (int i = 1; i < ROM_LAT; i++) side_pipe_q[i] <= side_pipe_q[i-1];
      end
   end

   // ---------------------------------------------------------------- FIFO
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      end else begin
         if (fifo_wr) begin
            mem_q[wr_ptr_q] <= arr_ent;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (fifo_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q <= cnt_q + 2'(fifo_wr) - 2'(fifo_rd);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(fifo_wr && !fifo_rd && (cnt_q == 2'(DEPTH))));

endmodule

// File: tb/tb_image_rom_scanner.sv
// ----------------------------------------------------------------------------
// tb_image_rom_scanner
//   Two scanners (ROM_LAT=1 and ROM_LAT=2) on a 4x2 image at BASE=0x800, each
//   with its own ROM model returning addr[8:0]. Directed frames cover full
//   rate, random backpressure, start while busy, start coinciding with done,
//   mirror (when IMAGE_SCAN_MIRROR_EN is defined) and a mid-frame reset.
// ----------------------------------------------------------------------------
module tb_image_rom_scanner;

   typedef struct {
      logic [13:0] val;   // {data, x, y, sof, eol}
      int          cyc;
   } rec_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start_s [2];
   logic       ready_s [2];
   logic       busy_s  [2];
   logic       done_s  [2];
   logic       valid_s [2];
   logic       sof_s   [2];
   logic       eol_s   [2];
   logic [11:0] ad_s   [2];
   logic [8:0] rd_s    [2];
   logic [8:0] pd_s    [2];
   logic [1:0] px_s    [2];
   logic       py_s    [2];
   logic [8:0] rom1_q;
`ifdef IMAGE_SCAN_MIRROR_EN
   logic       mirror_s [2];
`endif

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   done_cnt [2];
   int   vld_seen [2];
   bit   stab_en = 1'b1;
   bit   stall_q [2];
   logic [14:0] stall_v [2];
   rec_t mon0_q[$];
   rec_t mon1_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM models: data = addr[8:0], latency 1 and 2
   always @(posedge clk) rd_s[0] <= ad_s[0][8:0];
   always @(posedge clk) begin
      rom1_q  <= ad_s[1][8:0];
      rd_s[1] <= rom1_q;
   end

   image_rom_scanner #(.ADDR_W(12), .DATA_W(9), .IMG_W(4), .IMG_H(2), .BASE('h800), .ROM_LAT(1)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .start(start_s[0]),
`ifdef IMAGE_SCAN_MIRROR_EN
      .mirror(mirror_s[0]),
`endif
      .busy(busy_s[0]), .done(done_s[0]), .rom_ad(ad_s[0]), .rom_data(rd_s[0]),
      .pix_valid(valid_s[0]), .pix_ready(ready_s[0]), .pix_data(pd_s[0]),
      .pix_x(px_s[0]), .pix_y(py_s[0]), .pix_sof(sof_s[0]), .pix_eol(eol_s[0]));

   image_rom_scanner #(.ADDR_W(12), .DATA_W(9), .IMG_W(4), .IMG_H(2), .BASE('h800), .ROM_LAT(2)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start_s[1]),
`ifdef IMAGE_SCAN_MIRROR_EN
      .mirror(mirror_s[1]),
`endif
      .busy(busy_s[1]), .done(done_s[1]), .rom_ad(ad_s[1]), .rom_data(rd_s[1]),
      .pix_valid(valid_s[1]), .pix_ready(ready_s[1]), .pix_data(pd_s[1]),
      .pix_x(px_s[1]), .pix_y(py_s[1]), .pix_sof(sof_s[1]), .pix_eol(eol_s[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor on the falling edge: records handshakes, done pulses, and checks
   // that a stalled pixel is held unchanged into the next cycle.
   always @(negedge clk) begin
      if (reset_n) begin
         for (int k = 0; k < 2; k++) begin
            rec_t r;
            if (valid_s[k]) vld_seen[k]++;
            if (done_s[k])  done_cnt[k]++;
            if (valid_s[k] && ready_s[k]) begin
               r.val = {pd_s[k], px_s[k], py_s[k], sof_s[k], eol_s[k]};
               r.cyc = cyc;
               if (k == 0) mon0_q.push_back(r);
               else        mon1_q.push_back(r);
            end
            if (stab_en && stall_q[k])
               chk($sformatf("stall_hold%0d", k),
                   32'({valid_s[k], pd_s[k], px_s[k], py_s[k], sof_s[k], eol_s[k]}), 32'(stall_v[k]));
            stall_q[k] = valid_s[k] && !ready_s[k];
            stall_v[k] = {valid_s[k], pd_s[k], px_s[k], py_s[k], sof_s[k], eol_s[k]};
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon(input int k);
      if (k == 0) mon0_q.delete();
      else        mon1_q.delete();
      done_cnt[k] = 0;
      vld_seen[k] = 0;
   endtask

   function automatic logic [13:0] exp_pix(input int i, input bit mir);
      int x, y, d;
      x = i % 4;
      y = (i / 4) % 2;
      d = mir ? (y * 4 + 3 - x) : (y * 4 + x);
      return {9'(d), 2'(x), 1'(y), (x == 0 && y == 0), (x == 3)};
   endfunction

   // One frame on scanner k; rnd selects 30% ready duty, otherwise ready=1.
   task automatic run_frame(input int k, input bit rnd, input bit mir, input string nm);
      int   t0;
      rec_t q[$];
      clear_mon(k);
      ready_s[k] = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      start_s[k] = 1'b1;
      t0 = cyc;
      tick(1);
      start_s[k] = 1'b0;
      for (int c = 0; c < 400 && done_cnt[k] == 0; c++) begin
         ready_s[k] = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
         tick(1);
      end
      ready_s[k] = 1'b1;
      tick(4);
      if (k == 0) q = mon0_q; else q = mon1_q;
      chk({nm, "_done"}, 32'(done_cnt[k]), 32'd1);
      chk({nm, "_busy_end"}, 32'(busy_s[k]), 32'd0);
      chk({nm, "_count"}, 32'(q.size()), 32'd8);
      for (int i = 0; i < 8 && i < q.size(); i++) begin
         chk($sformatf("%s_pix%0d", nm, i), 32'(q[i].val), 32'(exp_pix(i, mir)));
         if (!rnd) chk($sformatf("%s_cyc%0d", nm, i), 32'(q[i].cyc - t0), 32'(2 + k + i));
      end
   endtask

   initial begin
      reset_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         start_s[k] = 1'b0; ready_s[k] = 1'b1; stall_q[k] = 1'b0;
         stall_v[k] = '0; done_cnt[k] = 0; vld_seen[k] = 0;
`ifdef IMAGE_SCAN_MIRROR_EN
         mirror_s[k] = 1'b0;
`endif
      end
      #1;
      chk("rst_busy",  32'(busy_s[0]),  32'd0);
      chk("rst_done",  32'(done_s[0]),  32'd0);
      chk("rst_valid", 32'(valid_s[0]), 32'd0);
      chk("rst_ad0",   32'(ad_s[0]),    32'h800);
      chk("rst_ad1",   32'(ad_s[1]),    32'h800);
      chk("rst_pix",   32'({pd_s[0], px_s[0], py_s[0], sof_s[0], eol_s[0]}), 32'd0);
      tick(3);
      @(negedge clk);
      #1 reset_n = 1'b1;
      tick(2);

      // full rate, then random backpressure, both latencies
      run_frame(0, 1'b0, 1'b0, "t2");
      run_frame(0, 1'b1, 1'b0, "t3");
      run_frame(1, 1'b0, 1'b0, "t5full");
      run_frame(1, 1'b1, 1'b0, "t5bp");

      // start while busy is ignored; start on the done cycle is accepted
      begin
         int   t0;
         rec_t q[$];
         clear_mon(0);
         ready_s[0] = 1'b1;
         t0 = cyc;
         for (int r = 0; r < 30; r++) begin
            start_s[0] = (r == 0 || r == 3 || r == 10);
            @(negedge clk);
            if (r == 0)  chk("t4_busy_r0", 32'(busy_s[0]), 32'd0);
            if (r == 1)  chk("t4_busy_r1", 32'(busy_s[0]), 32'd1);
            if (r == 10) chk("t4_done_at_start", 32'(done_s[0]), 32'd1);
            @(posedge clk);
            #1;
         end
         start_s[0] = 1'b0;
         q = mon0_q;
         chk("t4_done_cnt", 32'(done_cnt[0]), 32'd2);
         chk("t4_count", 32'(q.size()), 32'd16);
         for (int i = 0; i < 16 && i < q.size(); i++) begin
            chk($sformatf("t4_pix%0d", i), 32'(q[i].val), 32'(exp_pix(i % 8, 1'b0)));
            chk($sformatf("t4_cyc%0d", i), 32'(q[i].cyc - t0), 32'((i < 8) ? 2 + i : 12 + i - 8));
         end
         chk("t4_busy_end", 32'(busy_s[0]), 32'd0);
      end

`ifdef IMAGE_SCAN_MIRROR_EN
      mirror_s[0] = 1'b1;
      run_frame(0, 1'b0, 1'b1, "t6");
      mirror_s[0] = 1'b0;
`endif

      // asynchronous reset in the middle of SCAN with the FIFO backed up
      stab_en = 1'b0;
      clear_mon(0);
      ready_s[0] = 1'b0;
      start_s[0] = 1'b1;
      tick(1);
      start_s[0] = 1'b0;
      tick(2);
      chk("t1_busy_pre",  32'(busy_s[0]),  32'd1);
      chk("t1_valid_pre", 32'(valid_s[0]), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("t1_busy",  32'(busy_s[0]),  32'd0);
      chk("t1_done",  32'(done_s[0]),  32'd0);
      chk("t1_valid", 32'(valid_s[0]), 32'd0);
      chk("t1_ad",    32'(ad_s[0]),    32'h800);
      chk("t1_pix",   32'({pd_s[0], px_s[0], py_s[0], sof_s[0], eol_s[0]}), 32'd0);
      vld_seen[0] = 0;
      @(negedge clk);
      #1 reset_n = 1'b1;
      ready_s[0] = 1'b1;
      tick(12);
      chk("t1_no_valid_after", 32'(vld_seen[0]), 32'd0);
      chk("t1_busy_after",     32'(busy_s[0]),   32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
